// File: rtl/mux4x1_arbiter.sv
// Round-robin arbiter sharing one serial line among four requesters.
// Each grant owns the line for FRAME_LEN cycles; data_out is the gated 4:1 mux.
module mux4x1_arbiter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic       data_out
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SERVE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;

  logic [1:0]        base;
  logic [1:0]        idx;
  logic [1:0]        winner;
  logic              found;
  logic              frame_end;

  assign frame_end = busy_q && (cnt_q == '0);

  // At a frame end the just-served index becomes "last" for this search.
  always_comb begin
    base   = (state_q == SERVE) ? sel_q : last_q;
    idx    = 2'd0;
    winner = 2'd0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SERVE;
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          cnt_d   = LOAD;
        end
      end
      SERVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          last_d = sel_q;
          if (found) begin
            grant_d = 4'b0001 << winner;
            sel_d   = winner;
            cnt_d   = LOAD;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign done     = frame_end;
  assign data_out = busy_q & data_in[sel_q];

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Directed bench for mux4x1_arbiter: vector table plus hand-written frame sequences.
module tb_mux4x1_arbiter;

  logic       clk = 1'b0;
  logic       reset, reset1;
  logic [3:0] req, data_in, req1, data_in1;
  logic [3:0] grant, grant1;
  logic [1:0] sel, sel1;
  logic       busy, done, data_out, busy1, done1, data_out1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mux4x1_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant), .sel(sel), .busy(busy), .done(done), .data_out(data_out)
  );

  mux4x1_arbiter #(.FRAME_LEN(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset1), .req(req1), .data_in(data_in1),
    .grant(grant1), .sel(sel1), .busy(busy1), .done(done1), .data_out(data_out1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       d;
    logic       o;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] di,
                              input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic d, input logic o);
    vec_t v;
    v.rst = r; v.req = q; v.din = di; v.g = g; v.s = s; v.b = b; v.d = d; v.o = o;
    return v;
  endfunction

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] di);
    reset = r; req = q; data_in = di;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input bit which, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input logic d, input logic o);
    logic [8:0] act, exp;
    act = which ? {grant1, sel1, busy1, done1, data_out1} : {grant, sel, busy, done, data_out};
    exp = {g, s, b, d, o};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%b sel=%0d busy=%b done=%b dout=%b, want grant=%b sel=%0d busy=%b done=%b dout=%b",
                  name, act[8:5], act[4:3], act[2], act[1], act[0], g, s, b, d, o);
  endtask

  logic [3:0] din_tab [8];
  logic [3:0] r;
  logic [1:0] w;

  initial begin
    reset = 1'b1; req = 4'b0; data_in = 4'b0;
    reset1 = 1'b1; req1 = 4'b0; data_in1 = 4'b0;

    // Single request frame, then release.
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0));
    for (int k = 2; k <= 7; k++)
      vecs.push_back(mk(0, 4'b0000, (k == 3) ? 4'b0001 : 4'b1110, 4'b0001, 2'd0, 1, 0, k == 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0, 0, 0));
    // Requester 2 data passthrough, then IDLE gating with sel held at 2.
    din_tab[0] = 4'b0101; din_tab[1] = 4'b1010; din_tab[2] = 4'b0111; din_tab[3] = 4'b1110;
    din_tab[4] = 4'b1001; din_tab[5] = 4'b0010; din_tab[6] = 4'b1101; din_tab[7] = 4'b0011;
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, (k == 0) ? 4'b0100 : 4'b0000, din_tab[k], 4'b0100, 2'd2, 1,
                        k == 7, din_tab[k][2]));
    vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 2'd2, 0, 0, 0));

    @(posedge clk); #1;
    chk("dut1_reset", 1, 4'b0000, 2'd0, 0, 0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].din);
      chk($sformatf("vec%0d", i), 0, vecs[i].g, vecs[i].s, vecs[i].b, vecs[i].d, vecs[i].o);
    end

    // last=2, req=0101: search 3,0 picks 0, then 1,2 picks 2 with no gap.
    step(0, 4'b0101, 4'b0000);
    chk("rr_first", 0, 4'b0001, 2'd0, 1, 0, 0);
    for (int c = 1; c < 8; c++) begin
      step(0, 4'b0101, 4'b0000);
      chk($sformatf("rr_hold%0d", c), 0, 4'b0001, 2'd0, 1, c == 7, 0);
    end
    step(0, 4'b0101, 4'b0100);
    chk("rr_second", 0, 4'b0100, 2'd2, 1, 0, 1);
    for (int c = 1; c < 8; c++) begin
      step(0, 4'b0000, 4'b0000);
      chk($sformatf("rr_drop%0d", c), 0, 4'b0100, 2'd2, 1, c == 7, 0);
    end
    step(0, 4'b0000, 4'b0000);
    chk("rr_idle", 0, 4'b0000, 2'd2, 0, 0, 0);

    // All four requesting: 0,1,2,3,0 back to back.
    step(1, 4'b0000, 4'b0000);
    chk("full_reset", 0, 4'b0000, 2'd0, 0, 0, 0);
    for (int f = 0; f < 5; f++) begin
      w = 2'(f % 4);
      for (int c = 0; c < 8; c++) begin
        r = 4'($urandom_range(0, 15));
        step(0, 4'b1111, r);
        chk($sformatf("full_f%0d_c%0d", f, c), 0, 4'b0001 << w, w, 1, c == 7, r[w]);
      end
    end

    // Reset mid-frame restores last=3.
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b0010, 4'b0000);
    chk("mid_c1", 0, 4'b0010, 2'd1, 1, 0, 0);
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0010);
    chk("mid_c3", 0, 4'b0010, 2'd1, 1, 0, 1);
    step(1, 4'b1111, 4'b1111);
    chk("mid_reset", 0, 4'b0000, 2'd0, 0, 0, 0);
    step(0, 4'b1100, 4'b0000);
    chk("mid_after", 0, 4'b0100, 2'd2, 1, 0, 0);

    // One-cycle frames alternate between 0 and 1 with done held high.
    reset1 = 1'b0; req1 = 4'b0011; data_in1 = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      step(0, 4'b0000, 4'b0000);
      chk($sformatf("f1_k%0d", k), 1, (k % 2) ? 4'b0010 : 4'b0001, 2'(k % 2), 1, 1, 1);
    end
    req1 = 4'b0000;
    step(0, 4'b0000, 4'b0000);
    chk("f1_release", 1, 4'b0000, 2'd1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
